// File: rtl/ioctl_stream_tx_if.sv
// ioctl_stream_tx_if: signal bundle for the ioctl download bus and the
// byte-wide source port that feeds it.
//   master : driven by the transmitter (ioctl_stream_tx)
//   slave  : the side that supplies bytes and accepts ioctl strobes
// ioctl side : ioctl_download, ioctl_index, ioctl_addr, ioctl_dout,
//              ioctl_wr (master -> slave), ioctl_wait (slave -> master)
// source side: src_addr, src_rd (master -> slave),
//              src_data, src_valid (slave -> master)
interface ioctl_stream_tx_if #(
  parameter int ADDR_W = 25
);
  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic [ADDR_W-1:0] ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              ioctl_wr;
  logic              ioctl_wait;

  logic [ADDR_W-1:0] src_addr;
  logic              src_rd;
  logic [7:0]        src_data;
  logic              src_valid;

  modport master (
    output ioctl_download, ioctl_index, ioctl_addr, ioctl_dout, ioctl_wr,
    output src_addr, src_rd,
    input  ioctl_wait, src_data, src_valid
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_addr, ioctl_dout, ioctl_wr,
    input  src_addr, src_rd,
    output ioctl_wait, src_data, src_valid
  );
endinterface

// File: rtl/ioctl_stream_tx.sv
// ioctl_stream_tx: replays a byte source as an ioctl_download / ioctl_wr
// burst, standing in for the HPS so the core's loaders can be bootstrapped
// without host firmware.
//   clk_sys        : single clock, rising edge
//   RESET          : asynchronous, active-low reset
//   start          : begin a transfer (accepted only when idle)
//   index, length  : image index and byte count, latched on accepted start
//   busy           : high whenever not idle
//   done           : one-cycle pulse at the end of a transfer
//   bus (master)   : ioctl download bus plus byte-source fetch port
module ioctl_stream_tx #(
  parameter int ADDR_W = 25,
  parameter int WR_GAP = 2
) (
  input  logic              clk_sys,
  input  logic              RESET,
  input  logic              start,
  input  logic [7:0]        index,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  ioctl_stream_tx_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WRITE,
    S_GAP,
    S_FINISH
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;       // bytes already strobed
  logic [ADDR_W-1:0] len_q;     // latched byte count
  logic [7:0]        gap_cnt;   // remaining GAP cycles minus one
  logic              wr_armed;  // in WRITE with a byte waiting for its strobe

  logic [ADDR_W-1:0] cnt_inc;
  assign cnt_inc = cnt + ADDR_W'(1);

  // NOTE: the strobe is gated combinationally by ioctl_wait so that the
  // first cycle with wait low carries the strobe; a registered strobe would
  // lag the release of back-pressure by one cycle.
  assign bus.ioctl_wr = wr_armed & ~bus.ioctl_wait;

  // NOTE: every register, outputs included, is cleared by the asynchronous
  // reset so an interrupted transfer leaves nothing behind on the bus.
  always_ff @(posedge clk_sys or negedge RESET) begin
    if (!RESET) begin
      state              <= S_IDLE;
      cnt                <= '0;
      len_q              <= '0;
      gap_cnt            <= '0;
      wr_armed           <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      bus.ioctl_download <= 1'b0;
      bus.ioctl_index    <= '0;
      bus.ioctl_addr     <= '0;
      bus.ioctl_dout     <= '0;
      bus.src_addr       <= '0;
      bus.src_rd         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            bus.ioctl_index <= index;
            len_q           <= length;
            cnt             <= '0;
            busy            <= 1'b1;
            if (length != '0) begin
              state              <= S_FETCH;
              bus.ioctl_download <= 1'b1;
              bus.src_rd         <= 1'b1;
              bus.src_addr       <= '0;
            end else begin
              // Empty image: report completion without touching the bus.
              state <= S_FINISH;
              done  <= 1'b1;
            end
          end
        end

        S_FETCH: begin
          if (bus.src_valid) begin
            bus.ioctl_dout <= bus.src_data;
            bus.ioctl_addr <= cnt;
            bus.src_rd     <= 1'b0;
            wr_armed       <= 1'b1;
            state          <= S_WRITE;
          end
        end

        S_WRITE: begin
          if (!bus.ioctl_wait) begin
            wr_armed <= 1'b0;
            cnt      <= cnt_inc;
            if (WR_GAP != 0) begin
              state   <= S_GAP;
              gap_cnt <= 8'(WR_GAP - 1);
            end else if (cnt_inc < len_q) begin
              state        <= S_FETCH;
              bus.src_rd   <= 1'b1;
              bus.src_addr <= cnt_inc;
            end else begin
              state              <= S_FINISH;
              bus.ioctl_download <= 1'b0;
              done               <= 1'b1;
            end
          end
        end

        S_GAP: begin
          if (gap_cnt == 8'd0) begin
            // cnt was already advanced by the strobe that opened this gap.
            if (cnt < len_q) begin
              state        <= S_FETCH;
              bus.src_rd   <= 1'b1;
              bus.src_addr <= cnt;
            end else begin
              state              <= S_FINISH;
              bus.ioctl_download <= 1'b0;
              done               <= 1'b1;
            end
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end

        S_FINISH: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
